// File: rtl/matmul_ctrl_param.sv
// N x N matrix-multiply controller: streams A/B read addresses, accumulates N
// products per C element in one MAC and writes C through active-low strobes.
module matmul_ctrl_param #(
  parameter int LOG2N  = 6,
  parameter int DW     = 8,
  parameter int ACC_W  = 2*DW + LOG2N,
  parameter int RD_LAT = 1,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               transpose_b,
  output logic               busy,
  output logic               done,
  output logic               nce_ab,
  output logic [2*LOG2N-1:0] addr_a,
  output logic [2*LOG2N-1:0] addr_b,
  input  logic [DW-1:0]      rdata_a,
  input  logic [DW-1:0]      rdata_b,
  output logic               nce_c,
  output logic               nwrt_c,
  output logic [2*LOG2N-1:0] addr_c,
  output logic [ACC_W-1:0]   wdata_c
);

  localparam int AW = 2*LOG2N;
  localparam int CW = 3*LOG2N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tr_q, tr_d;
  logic [1:0]       drn_q, drn_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_c_q, addr_c_d;
  logic [ACC_W-1:0] wdata_c_q, wdata_c_d;

  // The step counter is {i, j, k}, so k runs fastest, then j, then i.
  logic [LOG2N-1:0] ci, cj, ck;
  logic             issue;

  assign ci    = cnt_q[CW-1 -: LOG2N];
  assign cj    = cnt_q[AW-1 -: LOG2N];
  assign ck    = cnt_q[LOG2N-1:0];
  assign issue = (state_q == S_ISSUE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tr_d    = tr_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          tr_d    = transpose_b;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        drn_d = '0;
        if (&cnt_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drn_q == 2'(RD_LAT)) state_d = S_DONE;
        else drn_d = drn_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flags and destination address ride alongside the read so they line up
  // with rdata RD_LAT cycles later.
  logic [RD_LAT-1:0] pv_q, pv_d, pf_q, pf_d, pl_q, pl_d;
  logic [AW-1:0]     pt_q [RD_LAT];
  logic [AW-1:0]     pt_d [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pv_d[gi] = issue;
        assign pf_d[gi] = (ck == '0);
        assign pl_d[gi] = &ck;
        assign pt_d[gi] = {ci, cj};
      end else begin : g_tail
        assign pv_d[gi] = pv_q[gi-1];
        assign pf_d[gi] = pf_q[gi-1];
        assign pl_d[gi] = pl_q[gi-1];
        assign pt_d[gi] = pt_q[gi-1];
      end
    end
  endgenerate

  logic signed [DW:0] ext_a, ext_b;
  logic [ACC_W-1:0]   prod;

  // Low ACC_W bits of the extended product equal the wrapped true product.
  always_comb begin
    ext_a = (SIGNED != 0) ? {rdata_a[DW-1], rdata_a} : {1'b0, rdata_a};
    ext_b = (SIGNED != 0) ? {rdata_b[DW-1], rdata_b} : {1'b0, rdata_b};
    prod  = ACC_W'(ext_a) * ACC_W'(ext_b);
  end

  always_comb begin
    acc_d     = acc_q;
    wr_d      = 1'b0;
    addr_c_d  = addr_c_q;
    wdata_c_d = wdata_c_q;
    if (pv_q[RD_LAT-1]) begin
      acc_d = pf_q[RD_LAT-1] ? prod : acc_q + prod;
      if (pl_q[RD_LAT-1]) begin
        wr_d      = 1'b1;
        addr_c_d  = pt_q[RD_LAT-1];
        wdata_c_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tr_q      <= 1'b0;
      drn_q     <= '0;
      acc_q     <= '0;
      wr_q      <= 1'b0;
      addr_c_q  <= '0;
      wdata_c_q <= '0;
      pv_q      <= '0;
      pf_q      <= '0;
      pl_q      <= '0;
      for (int n = 0; n < RD_LAT; n++) pt_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tr_q      <= tr_d;
      drn_q     <= drn_d;
      acc_q     <= acc_d;
      wr_q      <= wr_d;
      addr_c_q  <= addr_c_d;
      wdata_c_q <= wdata_c_d;
      pv_q      <= pv_d;
      pf_q      <= pf_d;
      pl_q      <= pl_d;
      for (int n = 0; n < RD_LAT; n++) pt_q[n] <= pt_d[n];
    end
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign nce_ab  = ~issue;
  assign addr_a  = {ci, ck};
  assign addr_b  = tr_q ? {cj, ck} : {ck, cj};
  assign nce_c   = ~wr_q;
  assign nwrt_c  = ~wr_q;
  assign addr_c  = addr_c_q;
  assign wdata_c = wdata_c_q;

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// Bench for matmul_ctrl_param: two configurations (N=2 unsigned RD_LAT=1 and
// N=4 signed RD_LAT=3), each with SRAM models and a cycle-accurate expectation model.
module tb_matmul_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int fin_cnt = 0;

  task automatic chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0d want %0d", cfg, nm, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int L    = (gi == 0) ? 1 : 2;
      localparam int RL   = (gi == 0) ? 1 : 3;
      localparam int SG   = (gi == 0) ? 0 : 1;
      localparam int EW   = 8;
      localparam int AW   = 2*L;
      localparam int ACW  = 2*EW + L;
      localparam int N    = 1 << L;
      localparam int NN   = N*N;
      localparam int N3   = NN*N;
      localparam logic [63:0] MASK = (64'd1 << ACW) - 64'd1;

      logic rst, start, transpose_b, busy, done, nce_ab, nce_c, nwrt_c;
      logic [AW-1:0]  addr_a, addr_b, addr_c;
      logic [EW-1:0]  rdata_a, rdata_b;
      logic [ACW-1:0] wdata_c;

      logic [EW-1:0] mem_a [NN];
      logic [EW-1:0] mem_b [NN];
      logic [AW-1:0] pa [RL];
      logic [AW-1:0] pb [RL];
      logic [63:0]   exp_c [NN];
      bit run_active = 1'b0;
      bit tr_cur     = 1'b0;
      int cyc        = 0;
      int wr_cnt     = 0;
      int done_cyc   = -1;
      int ab_log [8];

      matmul_ctrl_param #(
        .LOG2N(L), .DW(EW), .ACC_W(ACW), .RD_LAT(RL), .SIGNED(SG)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start), .transpose_b(transpose_b),
        .busy(busy), .done(done), .nce_ab(nce_ab),
        .addr_a(addr_a), .addr_b(addr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .nce_c(nce_c), .nwrt_c(nwrt_c), .addr_c(addr_c), .wdata_c(wdata_c)
      );

      // SRAM read model: data for an address appears RL cycles later.
      always @(posedge clk) begin
        pa[0] <= addr_a;
        pb[0] <= addr_b;
        for (int d = 1; d < RL; d++) begin
          pa[d] <= pa[d-1];
          pb[d] <= pb[d-1];
        end
      end
      assign rdata_a = mem_a[pa[RL-1]];
      assign rdata_b = mem_b[pb[RL-1]];

      function automatic longint val(input logic [EW-1:0] x);
        if (SG != 0) return longint'($signed(x));
        return longint'(x);
      endfunction

      task automatic build_exp(input bit tr);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            longint s = 0;
            for (int k = 0; k < N; k++)
              s += val(mem_a[i*N+k]) * (tr ? val(mem_b[j*N+k]) : val(mem_b[k*N+j]));
            exp_c[i*N+j] = 64'(s) & MASK;
          end
      endtask

      task automatic check_reset(input string tag);
        chk(gi, {tag, "_busy"},    64'(busy),    64'(0));
        chk(gi, {tag, "_done"},    64'(done),    64'(0));
        chk(gi, {tag, "_nce_ab"},  64'(nce_ab),  64'(1));
        chk(gi, {tag, "_nce_c"},   64'(nce_c),   64'(1));
        chk(gi, {tag, "_nwrt_c"},  64'(nwrt_c),  64'(1));
        chk(gi, {tag, "_addr_a"},  64'(addr_a),  64'(0));
        chk(gi, {tag, "_addr_b"},  64'(addr_b),  64'(0));
        chk(gi, {tag, "_addr_c"},  64'(addr_c),  64'(0));
        chk(gi, {tag, "_wdata_c"}, 64'(wdata_c), 64'(0));
      endtask

      // Expected outputs per cycle follow directly from the issue/write timeline.
      always @(negedge clk) begin : p_cmp
        int e, ii, jj, kk;
        bit wr;
        if (run_active) begin
          chk(gi, "busy",   64'(busy),   64'(cyc <= N3 + RL));
          chk(gi, "done",   64'(done),   64'(cyc == N3 + RL + 1));
          chk(gi, "nce_ab", 64'(nce_ab), 64'(cyc >= N3));
          if (cyc < N3) begin
            ii = cyc / NN;
            jj = (cyc / N) % N;
            kk = cyc % N;
            chk(gi, "addr_a", 64'(addr_a), 64'(ii*N + kk));
            chk(gi, "addr_b", 64'(addr_b), 64'(tr_cur ? jj*N + kk : kk*N + jj));
            if (cyc < 8) ab_log[cyc] = int'(addr_b);
          end
          e  = cyc - N - RL;
          wr = (e >= 0) && (e % N == 0) && (e / N < NN);
          chk(gi, "nce_c",  64'(nce_c),  64'(!wr));
          chk(gi, "nwrt_c", 64'(nwrt_c), 64'(!wr));
          if (wr) begin
            chk(gi, "addr_c",  64'(addr_c),  64'(e / N));
            chk(gi, "wdata_c", 64'(wdata_c), exp_c[e / N]);
          end
          if (!nce_c && !nwrt_c) wr_cnt++;
          if (done) done_cyc = cyc;
          if (cyc == N3 + RL + 1) run_active = 1'b0;
          cyc++;
        end else begin
          chk(gi, "idle_busy",   64'(busy),   64'(0));
          chk(gi, "idle_done",   64'(done),   64'(0));
          chk(gi, "idle_nce_ab", 64'(nce_ab), 64'(1));
          chk(gi, "idle_nce_c",  64'(nce_c),  64'(1));
          chk(gi, "idle_nwrt_c", 64'(nwrt_c), 64'(1));
        end
      end

      task automatic launch(input bit tr);
        build_exp(tr);
        tr_cur = tr;
        @(negedge clk); #1;
        transpose_b = tr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        transpose_b = ~tr;
        cyc = 0;
        wr_cnt = 0;
        done_cyc = -1;
        run_active = 1'b1;
      endtask

      // pulse_at: cycle in which start is raised again (must be ignored), -1 for none.
      task automatic run(input bit tr, input int pulse_at);
        launch(tr);
        for (int c = 0; c <= N3 + RL + 1; c++) begin
          start = (c == pulse_at);
          @(posedge clk); #1;
        end
        start = 1'b0;
        chk(gi, "wr_count", 64'(wr_cnt), 64'(NN));
        $display("cfg%0d run tr=%0d pulse=%0d writes=%0d done_cyc=%0d", gi, tr, pulse_at, wr_cnt, done_cyc);
      endtask

      task automatic reset_mid();
        launch(1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        run_active = 1'b0;
        #1;
        check_reset("mid");
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("cfg%0d reset mid-run at cycle 4", gi);
      endtask

      task automatic randomize_mems();
        for (int n = 0; n < NN; n++) begin
          mem_a[n] = EW'($urandom);
          mem_b[n] = EW'($urandom);
        end
      endtask

      task automatic power_on();
        rst = 1'b1;
        start = 1'b0;
        transpose_b = 1'b0;
        for (int n = 0; n < NN; n++) begin
          mem_a[n] = '0;
          mem_b[n] = '0;
        end
        #2;
        check_reset("por");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
      endtask

      if (gi == 0) begin : g_seq
        initial begin
          int ab_ref [8];
          ab_ref = '{0, 1, 2, 3, 0, 1, 2, 3};
          power_on();
          for (int n = 0; n < 4; n++) begin
            mem_a[n] = EW'(n + 1);
            mem_b[n] = EW'(n + 5);
          end
          run(1'b0, -1);
          chk(gi, "lit_c00", exp_c[0], 64'd19);
          chk(gi, "lit_c01", exp_c[1], 64'd22);
          chk(gi, "lit_c10", exp_c[2], 64'd43);
          chk(gi, "lit_c11", exp_c[3], 64'd50);
          chk(gi, "lit_done_cyc", 64'(done_cyc), 64'd10);
          run(1'b1, N3 + RL + 1);
          chk(gi, "lit_t_c00", exp_c[0], 64'd17);
          chk(gi, "lit_t_c01", exp_c[1], 64'd23);
          chk(gi, "lit_t_c10", exp_c[2], 64'd39);
          chk(gi, "lit_t_c11", exp_c[3], 64'd53);
          for (int c = 0; c < 8; c++) chk(gi, "lit_addr_b_seq", 64'(ab_log[c]), 64'(ab_ref[c]));
          for (int n = 0; n < 4; n++) begin
            mem_a[n] = 8'hFF;
            mem_b[n] = 8'hFF;
          end
          run(1'b0, 6);
          chk(gi, "lit_fullscale", exp_c[3], 64'd130050);
          reset_mid();
          for (int n = 0; n < 4; n++) begin
            mem_a[n] = EW'(n + 1);
            mem_b[n] = EW'(n + 5);
          end
          run(1'b0, -1);
          repeat (6) begin
            randomize_mems();
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, N3 + RL + 1)));
          end
          fin_cnt++;
        end
      end else begin : g_seq
        initial begin
          power_on();
          mem_a[0] = 8'h80;
          mem_a[1] = 8'h80;
          mem_a[4] = 8'h01;
          mem_b[0] = 8'h80;
          mem_b[4] = 8'h80;
          run(1'b0, 4);
          chk(gi, "lit_s_c00", exp_c[0], 64'd32768);
          chk(gi, "lit_s_c10", exp_c[4], 64'd262016);
          chk(gi, "lit_done_cyc", 64'(done_cyc), 64'd68);
          for (int n = 0; n < NN; n++) begin
            mem_a[n] = 8'h80;
            mem_b[n] = 8'h7F;
          end
          run(1'b1, -1);
          chk(gi, "lit_s_neg", exp_c[5], 64'd197120);
          repeat (5) begin
            randomize_mems();
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, N3 + RL + 1)));
          end
          fin_cnt++;
        end
      end
    end
  endgenerate

  initial begin
    for (int t = 0; t < 20000 && fin_cnt < 2; t++) @(posedge clk);
    chk(9, "finished_cfgs", 64'(fin_cnt), 64'(2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
